dz_image_sel: RTL
=================

# dz_image_sel

Parametrised image selector between the egg-hatching game core and the `dz_show` dot-matrix driver. It turns the growth count into an egg-stage image index and plays a timed "crack" frame at hatch. At hatch it draws one of `N_ANIMAL` animal images from a free-running LFSR and latches the pick until reset. A `fail` from the game core forces a death image, optionally blinking.

## Interface
- `NUM_W`, 5: width of `dz_num`.
- `STAGE_SHIFT`, 1: egg stage index = `dz_num >> STAGE_SHIFT`.
- `EGG_IMGS`, 8: number of egg-stage images, indices 0..`EGG_IMGS`-1.
- `HATCH_NUM`, 16: `dz_num` value at or above which hatching starts.
- `CRACK_IMG`, 12: image index shown during the crack phase.
- `CRACK_CYC`, 1000: crack phase length in clk cycles, ≥1.
- `ANIMAL_BASE`, 8: index of the first animal image.
- `N_ANIMAL`, 4: animal count; power of two, 1..8.
- `DEAD_IMG`, 13: image index on fail.
- `BLINK_CYC`, 500: blink half-period in cycles, ≥1; used only with `DZ_BLINK_EN`.
- `IMG_W`, 4: width of `img`.
- `clk` in 1: system clock, all logic on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `upd` in 1: one-cycle strobe that samples `dz_num`.
- `dz_num` in `NUM_W`: growth count from the game core.
- `fail` in 1: level; game lost.
- `img` out `IMG_W`: image index to `dz_show`.
- `hatched` out 1: high in HATCHED state.
- `blank` out 1: high means `dz_show` must blank the matrix.

## Operation
- The FSM has four states: EGG, CRACK, HATCHED, DEAD. All outputs are registered.
- **Reset** (`rst`=0 at a clk edge): state=EGG, `img`=0, `hatched`=0, `blank`=0, crack counter=0, blink counter=0, LFSR=8'hA5.
- **LFSR**: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. It steps every cycle in every state and never holds the value 0.
- **EGG**:
  - On `upd` with `dz_num` < `HATCH_NUM`: `img` = min(`dz_num` >> `STAGE_SHIFT`, `EGG_IMGS`-1).
  - On `upd` with `dz_num` ≥ `HATCH_NUM`: go to CRACK, `img`=`CRACK_IMG`, load the crack counter with `CRACK_CYC`-1, and latch `pick` = LFSR[log2(`N_ANIMAL`)-1:0]. With `N_ANIMAL`=1, `pick`=0.
  - Without `upd`: `img` holds.
- **CRACK**:
  - The counter decrements each cycle.
  - At 0, go to HATCHED: `img`=`ANIMAL_BASE`+`pick`, `hatched`=1.
  - `upd` and `dz_num` are ignored.
- **HATCHED**: `img` and `pick` hold until reset. `dz_num` is ignored, including values that drop back below `HATCH_NUM`.
- **DEAD**:
  - Entered from any state when `fail`=1 at a clk edge. `img`=`DEAD_IMG`, `hatched`=0.
  - DEAD is absorbing; only reset exits it. `fail` has priority over `upd` in the same cycle.
- **Arithmetic**: the image sum and the shift are computed at `IMG_W`. Parameters must keep all indices below 2^`IMG_W`; an elaboration-time check rejects violations.

## Timing
- `img` changes on the edge where `upd` is sampled, so it is visible 1 cycle after the strobe.
- Cycle numbering: the EGG→CRACK transition happens at edge t. HATCHED and the animal `img` appear at edge t+`CRACK_CYC`, so `img`=`CRACK_IMG` for exactly `CRACK_CYC` cycles.
- `fail` sampled at edge t sets `img`=`DEAD_IMG` at edge t, visible in the following cycle.
- Reset mid-CRACK aborts the crack phase. The next hatch redraws `pick` from the LFSR state at that moment.
- Back-to-back `upd` strobes are each honoured in EGG. No handshake; `upd` is never back-pressured.

## Configuration
- `DZ_BLINK_EN` defined: in DEAD, `blank` toggles every `BLINK_CYC` cycles. The first toggle to 1 comes `BLINK_CYC` cycles after DEAD entry.
- `DZ_BLINK_EN` undefined: `blank` is tied to 0 and the blink counter is not built.
- In all other states `blank`=0 in both builds.

## Test plan
- Reset, then `upd` with `dz_num`=0,5,15 → `img`=0,2,7, each one cycle after its strobe; `hatched`=0.
- `upd` with `dz_num`=16 and `CRACK_CYC`=4 → `img`=12 for 4 cycles, then `img`=8+`pick` with `pick` matching the reference-model LFSR bits at entry; `hatched`=1.
- In HATCHED, `upd` with `dz_num`=3 → `img` unchanged, `hatched` stays 1.
- `fail`=1 together with `upd` (`dz_num`=16) in EGG → `img`=13, state DEAD, no CRACK. With `DZ_BLINK_EN` and `BLINK_CYC`=3, `blank` reads 0,0,0,1,1,1,0… after entry.
- Assert `rst`=0 two cycles into CRACK → next cycle `img`=0, `hatched`=0. Run 1000 rehatch cycles with varying reset release times → all 4 `pick` values occur and `img` never exceeds 11 while hatched.

Source files
------------

// File: rtl/dz_image_sel.sv
// dz_image_sel: picks the image index shown by the dz_show dot-matrix driver.
//
// Egg growth count -> egg-stage image, a timed crack frame at hatch, then an
// animal image drawn from a free-running LFSR and held until reset. A fail
// level from the game core forces a death image.
//
// Optional feature macro: DZ_BLINK_EN
//   defined   : blank toggles every BLINK_CYC cycles while in DEAD
//   undefined : blank is tied low and the blink counter is not built
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous, active-low reset
//   upd      in   one-cycle strobe sampling dz_num
//   dz_num   in   growth count from the game core (NUM_W bits)
//   fail     in   level, game lost; beats upd in the same cycle
//   img      out  registered image index to dz_show (IMG_W bits)
//   hatched  out  registered, high in HATCHED
//   blank    out  registered, high asks dz_show to blank the matrix
module dz_image_sel #(
  parameter int unsigned NUM_W       = 5,
  parameter int unsigned STAGE_SHIFT = 1,
  parameter int unsigned EGG_IMGS    = 8,
  parameter int unsigned HATCH_NUM   = 16,
  parameter int unsigned CRACK_IMG   = 12,
  parameter int unsigned CRACK_CYC   = 1000,
  parameter int unsigned ANIMAL_BASE = 8,
  parameter int unsigned N_ANIMAL    = 4,
  parameter int unsigned DEAD_IMG    = 13,
  parameter int unsigned BLINK_CYC   = 500,
  parameter int unsigned IMG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd,
  input  logic [NUM_W-1:0] dz_num,
  input  logic             fail,
  output logic [IMG_W-1:0] img,
  output logic             hatched,
  output logic             blank
);

  localparam int unsigned CrackW   = $clog2(CRACK_CYC + 1);
  localparam int unsigned ImgLimit = 1 << IMG_W;

  // Every index that can reach img must fit in IMG_W bits.
  localparam bit ParamsOk =
      (CRACK_CYC >= 1) && (BLINK_CYC >= 1) && (EGG_IMGS >= 1) &&
      (N_ANIMAL >= 1) && (N_ANIMAL <= 8) && ((N_ANIMAL & (N_ANIMAL - 1)) == 0) &&
      (EGG_IMGS - 1 < ImgLimit) && (CRACK_IMG < ImgLimit) && (DEAD_IMG < ImgLimit) &&
      (ANIMAL_BASE + N_ANIMAL - 1 < ImgLimit);

  if (!ParamsOk) begin : g_param_check
    $error("dz_image_sel: parameter set produces an image index outside IMG_W");
  end

  typedef enum logic [1:0] {StEgg, StCrack, StHatched, StDead} state_e;

  state_e             state_q, state_d;
  logic [IMG_W-1:0]   img_q, img_d;
  logic               hatched_q, hatched_d;
  logic [CrackW-1:0]  crack_q, crack_d;
  logic [2:0]         pick_q, pick_d;
  logic [7:0]         lfsr_q, lfsr_d;

  logic               hatch_req;
  logic [NUM_W-1:0]   stage_raw;
  logic [IMG_W-1:0]   egg_img;
  logic [IMG_W-1:0]   animal_img;

  // Hatch threshold compared at 32 bits so HATCH_NUM may exceed the dz_num range.
  assign hatch_req = (32'(dz_num) >= HATCH_NUM);
  assign stage_raw = dz_num >> STAGE_SHIFT;

  // Clamp before narrowing so large counts saturate at the last egg image.
  always_comb begin
    if (32'(stage_raw) > EGG_IMGS - 1) begin
      egg_img = IMG_W'(EGG_IMGS - 1);
    end else begin
      egg_img = IMG_W'(stage_raw);
    end
  end

  assign animal_img = IMG_W'(ANIMAL_BASE) + IMG_W'(pick_q);

  // Galois LFSR, x^8+x^6+x^5+x^4+1 (right-shift mask 8'hB8). Maximal length, so a
  // nonzero seed never reaches zero.
  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StEgg;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; fail wins from every state and DEAD is absorbing.
  always_comb begin
    state_d = state_q;
    if (fail) begin
      state_d = StDead;
    end else begin
      unique case (state_q)
        StEgg:     if (upd && hatch_req) state_d = StCrack;
        StCrack:   if (crack_q == '0) state_d = StHatched;
        StHatched: state_d = StHatched;
        StDead:    state_d = StDead;
      endcase
    end
  end

  // Output / datapath next values; everything is registered below.
  always_comb begin
    img_d     = img_q;
    hatched_d = hatched_q;
    crack_d   = crack_q;
    pick_d    = pick_q;
    if (fail) begin
      img_d     = IMG_W'(DEAD_IMG);
      hatched_d = 1'b0;
    end else begin
      case (state_q)
        StEgg: begin
          if (upd) begin
            if (hatch_req) begin
              img_d   = IMG_W'(CRACK_IMG);
              crack_d = CrackW'(CRACK_CYC - 1);
              // Masking the low LFSR bits gives pick = 0 when N_ANIMAL = 1.
              pick_d  = lfsr_q[2:0] & 3'(N_ANIMAL - 1);
            end else begin
              img_d = egg_img;
            end
          end
        end
        StCrack: begin
          if (crack_q == '0) begin
            img_d     = animal_img;
            hatched_d = 1'b1;
          end else begin
            crack_d = crack_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      img_q     <= '0;
      hatched_q <= 1'b0;
      crack_q   <= '0;
      pick_q    <= '0;
      lfsr_q    <= 8'hA5;
    end else begin
      img_q     <= img_d;
      hatched_q <= hatched_d;
      crack_q   <= crack_d;
      pick_q    <= pick_d;
      lfsr_q    <= lfsr_d;
    end
  end

  assign img     = img_q;
  assign hatched = hatched_q;

`ifdef DZ_BLINK_EN
  localparam int unsigned BlinkW = $clog2(BLINK_CYC + 1);

  logic [BlinkW-1:0] blink_q, blink_d;
  logic              blank_q, blank_d;

  // Counter is loaded on DEAD entry so the first rise lands BLINK_CYC cycles later.
  always_comb begin
    blink_d = blink_q;
    blank_d = blank_q;
    if (state_q != StDead) begin
      blank_d = 1'b0;
      if (state_d == StDead) begin
        blink_d = BlinkW'(BLINK_CYC - 1);
      end
    end else if (blink_q == '0) begin
      blank_d = ~blank_q;
      blink_d = BlinkW'(BLINK_CYC - 1);
    end else begin
      blink_d = blink_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_q <= '0;
      blank_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

endmodule
